// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: fetch FSM states and
// architectural constants used across stages.
package mips_pkg;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [5:0]  OP_BEQ    = 6'b000100;

   function automatic logic [31:0] sext16_to_32(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target for beq: word-aligned branch address + 4 + sign-extended
// word offset, wrapping modulo 2^32.
module branch_target_calc
   import mips_pkg::*;
(
   input  logic [31:0] br_pc,
   input  logic [15:0] br_offset,
   output logic [31:0] target
);

   logic [31:0] base_s;
   logic [31:0] sext_s;
   logic [31:0] disp_s;
   logic        unused_pc_lsb_s;

   assign unused_pc_lsb_s = ^br_pc[1:0];

   // Target adder
   always_comb begin
      base_s = {br_pc[31:2], 2'b00} + PC_STEP;
      sext_s = sext16_to_32(br_offset);
      disp_s = {sext_s[29:0], 2'b00};
      target = base_s + disp_s;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, single-outstanding imem reads,
// valid/ready hand-off to decode, and branch redirect with wrong-path squash.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc_plus4,
   input  logic             br_taken,
   input  logic [31:0]      br_pc,
   input  logic [15:0]      br_offset,
   output logic [CNT_W-1:0] squash_cnt
);

   fetch_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic             imem_req_q, imem_req_d;
   logic             id_valid_q, id_valid_d;
   logic [31:0]      id_instr_q, id_instr_d;
   logic [31:0]      id_pc_q, id_pc_d;
   logic [31:0]      id_pc_plus4_q, id_pc_plus4_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
   logic [31:0]      target_s;
   logic [31:0]      pc_plus4_s;
   logic             squash_inc_s;

   branch_target_calc u_btc (
      .br_pc     (br_pc),
      .br_offset (br_offset),
      .target    (target_s)
   );

   // Next-state, PC and decode-output computation
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      id_valid_d    = id_valid_q;
      id_instr_d    = id_instr_q;
      id_pc_d       = id_pc_q;
      id_pc_plus4_d = id_pc_plus4_q;
      squash_inc_s  = 1'b0;
      pc_plus4_s    = pc_q + PC_STEP;

      if (br_taken) begin
         pc_d       = target_s;
         id_valid_d = 1'b0;
         case (state_q)
            // The cycle right after reset has no request in flight yet.
            ISSUE: begin
               if (imem_req_q) begin
                  state_d      = DROP;
                  squash_inc_s = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
            WAIT: begin
               squash_inc_s = 1'b1;
               if (imem_rsp_valid) begin
                  state_d = ISSUE;
               end else begin
                  state_d = DROP;
               end
            end
            HOLD: begin
               squash_inc_s = 1'b1;
               state_d      = ISSUE;
            end
            DROP: begin
               squash_inc_s = 1'b1;
               if (imem_rsp_valid) begin
                  state_d = ISSUE;
               end else begin
                  state_d = DROP;
               end
            end
            default: state_d = ISSUE;
         endcase
      end else begin
         case (state_q)
            ISSUE: begin
               if (imem_req_q) begin
                  state_d = WAIT;
               end else begin
                  state_d = ISSUE;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  id_instr_d    = imem_rsp_data;
                  id_pc_d       = pc_q;
                  id_pc_plus4_d = pc_plus4_s;
                  id_valid_d    = 1'b1;
                  pc_d          = pc_plus4_s;
                  state_d       = HOLD;
               end else begin
                  state_d = WAIT;
               end
            end
            HOLD: begin
               if (id_ready) begin
                  id_valid_d = 1'b0;
                  state_d    = ISSUE;
               end else begin
                  state_d = HOLD;
               end
            end
            DROP: begin
               if (imem_rsp_valid) begin
                  state_d = ISSUE;
               end else begin
                  state_d = DROP;
               end
            end
            default: state_d = ISSUE;
         endcase
      end

      if (squash_inc_s && (squash_cnt_q != {CNT_W{1'b1}})) begin
         squash_cnt_d = squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         squash_cnt_d = squash_cnt_q;
      end

      // Request is registered so it is high exactly during ISSUE cycles.
      imem_req_d = (state_d == ISSUE);
   end

   // State, PC and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ISSUE;
         pc_q          <= RESET_PC;
         imem_req_q    <= 1'b0;
         id_valid_q    <= 1'b0;
         id_instr_q    <= INSTR_NOP;
         id_pc_q       <= 32'h0000_0000;
         id_pc_plus4_q <= 32'h0000_0000;
         squash_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         imem_req_q    <= imem_req_d;
         id_valid_q    <= id_valid_d;
         id_instr_q    <= id_instr_d;
         id_pc_q       <= id_pc_d;
         id_pc_plus4_q <= id_pc_plus4_d;
         squash_cnt_q  <= squash_cnt_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign id_valid    = id_valid_q;
   assign id_instr    = id_instr_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_plus4_q;
   assign squash_cnt  = squash_cnt_q;

endmodule
